// File: rtl/pc_jump_16_if.sv
// rtl/pc_jump_16_if.sv - control/status bundle between the Hack CPU core and pc_jump_16 (PC_TRACE_EN adds prev_pc)
interface pc_jump_16_if;
  logic        en;
  logic        is_c;
  logic [2:0]  jmp;
  logic        zr;
  logic        ng;
  logic [15:0] target;
  logic [15:0] pc;
  logic        taken;
  logic        halted;
`ifdef PC_TRACE_EN
  logic [15:0] prev_pc;
`endif

  modport master (
    output en, is_c, jmp, zr, ng, target,
    input  pc, taken, halted
`ifdef PC_TRACE_EN
    , input prev_pc
`endif
  );

  modport slave (
    input  en, is_c, jmp, zr, ng, target,
    output pc, taken, halted
`ifdef PC_TRACE_EN
    , output prev_pc
`endif
  );
endinterface

// File: rtl/pc_jump_16.sv
// rtl/pc_jump_16.sv - Hack CPU program counter with jump evaluation and self-loop halt (optional PC_TRACE_EN)
module pc_jump_16 #(
  parameter logic [15:0] RESET_VEC   = 16'h0000,
  parameter bit          HALT_DETECT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  pc_jump_16_if.slave  bus
);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t      state;
  logic [15:0] pc_q;
  logic        taken_q;
  logic        halted_q;
  logic        cond;
  logic        self_loop;

  // zr&ng together is illegal from the ALU; the formula is applied as-is.
  always_comb begin
    cond = bus.is_c & ((bus.jmp[2] & bus.ng) |
                       (bus.jmp[1] & bus.zr) |
                       (bus.jmp[0] & ~bus.ng & ~bus.zr));
    self_loop = HALT_DETECT & bus.is_c & (bus.jmp == 3'b111) & (bus.target == pc_q);
  end

`ifdef PC_TRACE_EN
  logic [15:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= RESET_VEC;
    end else if (state == RUN && bus.en) begin
      prev_q <= pc_q;
    end
  end

  assign bus.prev_pc = prev_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc_q     <= RESET_VEC;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.en) begin
            if (self_loop) begin
              // Unconditional jump to itself: park until reset.
              state    <= HALTED;
              pc_q     <= bus.target;
              taken_q  <= 1'b1;
              halted_q <= 1'b1;
            end else if (cond) begin
              pc_q    <= bus.target;
              taken_q <= 1'b1;
            end else begin
              pc_q    <= pc_q + 16'd1;
              taken_q <= 1'b0;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign bus.pc     = pc_q;
  assign bus.taken  = taken_q;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_pc_jump_16.sv
// tb/tb_pc_jump_16.sv - randomized and directed check of pc_jump_16 (both HALT_DETECT settings) against a reference model
module tb_pc_jump_16;

  logic        clk;
  logic        reset;
  logic        en;
  logic        is_c;
  logic [2:0]  jmp;
  logic        zr;
  logic        ng;
  logic [15:0] target;

  int total = 0;
  int bad   = 0;

  pc_jump_16_if bus0 ();
  pc_jump_16_if bus1 ();

  assign bus0.en = en;     assign bus1.en = en;
  assign bus0.is_c = is_c; assign bus1.is_c = is_c;
  assign bus0.jmp = jmp;   assign bus1.jmp = jmp;
  assign bus0.zr = zr;     assign bus1.zr = zr;
  assign bus0.ng = ng;     assign bus1.ng = ng;
  assign bus0.target = target; assign bus1.target = target;

  pc_jump_16 #(.RESET_VEC(16'h0000), .HALT_DETECT(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  pc_jump_16 #(.RESET_VEC(16'h0000), .HALT_DETECT(1'b0)) dut_nohalt (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state, index 0 = halt detection on, 1 = off.
  int m_pc[2];
  int m_prev[2];
  bit m_taken[2];
  bit m_halted[2];
  bit hd[2] = '{1'b1, 1'b0};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit want_jump(bit c, logic [2:0] j, bit z, bit n);
    bit lt, eq, gt;
    lt = n;
    eq = z;
    gt = !z && !n;
    return c && ((j[2] && lt) || (j[1] && eq) || (j[0] && gt));
  endfunction

  task automatic model_update(input int k);
    if (reset) begin
      m_pc[k] = 0; m_prev[k] = 0; m_taken[k] = 0; m_halted[k] = 0;
    end else if (!m_halted[k] && en) begin
      m_prev[k] = m_pc[k];
      if (hd[k] && is_c && jmp == 3'd7 && int'(target) == m_pc[k]) begin
        m_halted[k] = 1; m_taken[k] = 1; m_pc[k] = target;
      end else if (want_jump(is_c, jmp, zr, ng)) begin
        m_pc[k] = target; m_taken[k] = 1;
      end else begin
        m_pc[k] = (m_pc[k] + 1) % 65536; m_taken[k] = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit c, input logic [2:0] j,
                      input bit z, input bit n, input logic [15:0] t);
    reset = r; en = e; is_c = c; jmp = j; zr = z; ng = n; target = t;
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    check("pc0", bus0.pc, 16'(m_pc[0]));
    check("taken0", {15'd0, bus0.taken}, {15'd0, m_taken[0]});
    check("halted0", {15'd0, bus0.halted}, {15'd0, m_halted[0]});
    check("pc1", bus1.pc, 16'(m_pc[1]));
    check("taken1", {15'd0, bus1.taken}, {15'd0, m_taken[1]});
    check("halted1", {15'd0, bus1.halted}, {15'd0, m_halted[1]});
`ifdef PC_TRACE_EN
    check("prev0", bus0.prev_pc, 16'(m_prev[0]));
    check("prev1", bus1.prev_pc, 16'(m_prev[1]));
`endif
  endtask

  task automatic goto(input logic [15:0] v);
    step(0, 1, 1, 3'b111, 0, 0, v);
  endtask

  initial begin
    logic [15:0] t;
    bit z, n;
    reset = 1; en = 0; is_c = 0; jmp = 0; zr = 0; ng = 0; target = 0;

    // Reset then sequential fetch
    step(1, 0, 0, 3'b000, 0, 0, 16'h0);
    check("rst_pc", bus0.pc, 16'h0000);
    check("rst_taken", {15'd0, bus0.taken}, 16'd0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, 3'b000, 0, 0, 16'h0);
      check("seq_pc", bus0.pc, 16'(i));
    end

    // JEQ taken / not taken
    goto(16'h0005);
    step(0, 1, 1, 3'b010, 1, 0, 16'h0040);
    check("jeq_pc", bus0.pc, 16'h0040);
    check("jeq_taken", {15'd0, bus0.taken}, 16'd1);
    goto(16'h0005);
    step(0, 1, 1, 3'b010, 0, 0, 16'h0040);
    check("jeq_n_pc", bus0.pc, 16'h0006);
    check("jeq_n_taken", {15'd0, bus0.taken}, 16'd0);

    // Full jump-bit sweep over legal flag combinations
    for (int j = 0; j < 8; j++) begin
      for (int f = 0; f < 3; f++) begin
        z = (f == 1);
        n = (f == 2);
        goto(16'h0010);
        step(0, 1, 1, 3'(j), z, n, 16'h0100);
        check("sweep", bus0.pc, want_jump(1, 3'(j), z, n) ? 16'h0100 : 16'h0011);
      end
    end

    // Wrap and stall
    goto(16'hFFFF);
    step(0, 1, 0, 3'b000, 0, 0, 16'h0);
    check("wrap", bus0.pc, 16'h0000);
    step(0, 0, 1, 3'b111, 0, 0, 16'h0123);
    step(0, 0, 1, 3'b111, 0, 0, 16'h0456);
    check("stall_pc", bus0.pc, 16'h0000);
    check("stall_taken", {15'd0, bus0.taken}, 16'd0);

    // Self-loop halt
    goto(16'h0020);
    step(0, 1, 1, 3'b011, 0, 0, 16'h0020);
    check("cond_self_nohalt", {15'd0, bus0.halted}, 16'd0);
    goto(16'h0020);
    step(0, 1, 1, 3'b111, 0, 0, 16'h0020);
    check("halt", {15'd0, bus0.halted}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 3'b111, 0, 0, 16'h0020);
      check("nohalt_pc", bus1.pc, 16'h0020);
      check("nohalt_flag", {15'd0, bus1.halted}, 16'd0);
    end
    step(0, 1, 1, 3'b111, 0, 0, 16'h0777);
    step(0, 1, 0, 3'b000, 0, 0, 16'h0000);
    check("halt_hold", bus0.pc, 16'h0020);
    step(1, 1, 1, 3'b111, 0, 0, 16'h0020);
    check("halt_rst_pc", bus0.pc, 16'h0000);
    check("halt_rst_flag", {15'd0, bus0.halted}, 16'd0);

    // Reset wins over jump and over halt condition
    goto(16'h0007);
    step(0, 1, 1, 3'b111, 0, 0, 16'h0300);
`ifdef PC_TRACE_EN
    check("trace_prev", bus0.prev_pc, 16'h0007);
`endif
    step(1, 1, 1, 3'b111, 0, 0, 16'h0300);
    check("rst_jump_pc", bus0.pc, 16'h0000);
    check("rst_jump_taken", {15'd0, bus0.taken}, 16'd0);
    step(1, 1, 1, 3'b111, 0, 0, 16'h0000);
    check("rst_vs_halt", {15'd0, bus0.halted}, 16'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      t = ($urandom_range(0, 5) == 0) ? 16'(m_pc[$urandom_range(0, 1)]) : 16'($urandom);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) < 7,
           3'($urandom), 1'($urandom), 1'($urandom), t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
